// File: rtl/vector_instr_sequencer.sv
// Issues a stored program of ADD/MUL/LOAD/STORE vector instructions one at a time,
// holding the issued fields through a per-class latency window. Define SEQ_LOOP_EN for multi-pass runs.
module vector_instr_sequencer #(
  parameter int AW      = 4,
  parameter int ALU_LAT = 4,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
`ifdef SEQ_LOOP_EN
  input  logic [7:0]    loop_count,
`endif
  output logic          busy,
  output logic          done,
  output logic [1:0]    opcode,
  output logic [1:0]    reg_address,
  output logic [4:0]    memory_address,
  output logic          issue_valid,
  input  logic          issue_ready
);

  localparam int DEPTH   = 2**AW;
  localparam int PW      = AW + 1;
  localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [PW-1:0] DEPTH_L = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] PC_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [8:0]    r_mem [DEPTH];
  logic [8:0]    r_word;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] r_len;
  logic [PW-1:0] w_len_clamped;
  logic [CW-1:0] r_cnt;
  logic          w_last_wait;
  logic          w_last_instr;
  logic          w_final_pass;

  assign w_len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_last_wait   = (r_state == S_WAIT) && (r_cnt == CNT_ONE);
  assign w_last_instr  = (r_pc == r_len - PC_ONE);

`ifdef SEQ_LOOP_EN
  logic [7:0] r_loops;
  assign w_final_pass = (r_loops == 8'd0);
`else
  assign w_final_pass = 1'b1;
`endif

  // NOTE: the program RAM has no reset, so a loaded program survives rst and can be rerun.
  always_ff @(posedge clk) begin
    if (prog_we && (r_state == S_IDLE)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (prog_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: if (issue_ready) w_next = S_WAIT;
      S_WAIT:  if (w_last_wait) w_next = (w_last_instr && w_final_pass) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    issue_valid = 1'b0;
    unique case (r_state)
      S_FETCH, S_WAIT: busy = 1'b1;
      S_ISSUE: begin
        busy        = 1'b1;
        issue_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // r_word doubles as the registered RAM read port and the held issue fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_pc    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
`ifdef SEQ_LOOP_EN
      r_loops <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= w_len_clamped;
            r_pc    <= '0;
`ifdef SEQ_LOOP_EN
            r_loops <= loop_count;
`endif
          end
        end
        S_FETCH: r_word <= r_mem[r_pc[AW-1:0]];
        S_ISSUE: begin
          if (issue_ready) begin
            r_cnt <= r_word[8] ? CW'(MEM_LAT) : CW'(ALU_LAT);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last_wait && !w_last_instr) begin
            r_pc <= r_pc + PC_ONE;
          end else if (w_last_wait && !w_final_pass) begin
            r_pc    <= '0;
`ifdef SEQ_LOOP_EN
            r_loops <= r_loops - 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign opcode         = r_word[8:7];
  assign reg_address    = r_word[6:5];
  assign memory_address = r_word[4:0];

endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Self-checking bench for vector_instr_sequencer: a timestamp/queue model of the issue
// schedule is compared every cycle, with literal timing expectations pinning the model.
`timescale 1ns/1ps
module tb_vector_instr_sequencer;

  localparam int AW      = 4;
  localparam int PW      = AW + 1;
  localparam int DEPTH   = 2**AW;
  localparam int ALU_LAT = 4;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [8:0]    prog_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          issue_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [1:0]    opcode;
  logic [1:0]    reg_address;
  logic [4:0]    memory_address;
  logic          issue_valid;
`ifdef SEQ_LOOP_EN
  logic [7:0]    loop_count = '0;
`endif

  always #5 clk = ~clk;

  vector_instr_sequencer #(.AW(AW), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_len       (prog_len),
    .start          (start),
`ifdef SEQ_LOOP_EN
    .loop_count     (loop_count),
`endif
    .busy           (busy),
    .done           (done),
    .opcode         (opcode),
    .reg_address    (reg_address),
    .memory_address (memory_address),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready)
  );

  // Instruction words {opcode, reg, mem}
  localparam logic [8:0] W_LOAD_1_5  = {2'd2, 2'd1, 5'd5};
  localparam logic [8:0] W_ADD_0_0   = {2'd0, 2'd0, 5'd0};
  localparam logic [8:0] W_STORE_1_9 = {2'd3, 2'd1, 5'd9};
  localparam logic [8:0] W_MUL_2_7   = {2'd1, 2'd2, 5'd7};
  localparam logic [8:0] W_MUL_2_3   = {2'd1, 2'd2, 5'd3};
  localparam logic [8:0] W_STORE_2_4 = {2'd3, 2'd2, 5'd4};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int ready_mode = 0;

  int         hs_cyc[$];
  logic [8:0] hs_word[$];
  int         done_cyc[$];
  int         busy_cnt  = 0;
  int         valid_cnt = 0;
  bit         last_valid = 1'b0;
  logic [8:0] last_word  = '0;

  // Behavioural model: program copy, queue of words still to issue, and timestamps.
  logic [8:0] m_prog [DEPTH];
  logic [8:0] m_q[$];
  int         m_done_at    = -1;
  int         m_present_at = 0;
  bit         m_running    = 1'b0;
  bit         m_active     = 1'b0;
  bit         e_busy  = 1'b0;
  bit         e_done  = 1'b0;
  bit         e_valid = 1'b0;
  logic [8:0] e_word  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [8:0] w);
    return (w[8:7] >= 2'd2) ? MEM_LAT : ALU_LAT;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    bit was_idle;
    bit was_valid;
    int len;
    int passes;
    int lat;
    was_idle  = !e_busy && !e_done;
    was_valid = e_valid;
    if (prog_we && was_idle) m_prog[prog_addr] = prog_data;
    if (rst) begin
      m_active  = 1'b1;
      m_running = 1'b0;
      m_q.delete();
      m_done_at = -1;
      e_busy = 1'b0; e_done = 1'b0; e_valid = 1'b0; e_word = '0;
      return;
    end
    if (!m_active) return;
    if (was_idle && start) begin
      len = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
`ifdef SEQ_LOOP_EN
      passes = int'(loop_count) + 1;
`else
      passes = 1;
`endif
      if (len == 0) begin
        m_done_at = cyc;
      end else begin
        for (int p = 0; p < passes; p++)
          for (int i = 0; i < len; i++) m_q.push_back(m_prog[i]);
        m_running    = 1'b1;
        m_present_at = cyc + 1;
        m_done_at    = -1;
      end
    end else if (was_valid && issue_ready) begin
      lat = lat_of(m_q[0]);
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done_at = cyc + lat;
      else                 m_present_at = cyc + lat + 1;
    end
    e_done = (cyc == m_done_at);
    if (e_done) m_running = 1'b0;
    e_busy  = m_running;
    e_valid = m_running && (m_q.size() > 0) && (cyc >= m_present_at);
    if (e_valid) e_word = m_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_active && !rst && last_valid && issue_ready) begin
      hs_cyc.push_back(cyc - t0);
      hs_word.push_back(last_word);
    end
    cyc++;
    model_edge();
    @(negedge clk);
    if (m_active) begin
      check("cycle_outputs", {busy, done, issue_valid, opcode, reg_address, memory_address},
            {e_busy, e_done, e_valid, e_word});
      if (done === 1'b1) done_cyc.push_back(cyc - t0);
      if (busy === 1'b1) busy_cnt++;
      if (issue_valid === 1'b1) valid_cnt++;
    end
    last_valid = (issue_valid === 1'b1);
    last_word  = {opcode, reg_address, memory_address};
  endtask

  task automatic step();
    case (ready_mode)
      1:       issue_ready = 1'($urandom_range(0, 1));
      2:       issue_ready = !(((cyc - t0) >= 2) && ((cyc - t0) <= 4));
      default: issue_ready = 1'b1;
    endcase
    tick();
  endtask

  task automatic write_prog(input int addr, input logic [8:0] word);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = word;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic start_run(input int len);
    prog_len = PW'(len);
    start    = 1'b1;
    t0       = cyc;
    hs_cyc.delete();
    hs_word.delete();
    done_cyc.delete();
    busy_cnt  = 0;
    valid_cnt = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((done_cyc.size() == 0) && (n < budget)) begin
      step();
      n++;
    end
    step();
    step();
    check("single_done_pulse", done_cyc.size(), 1);
  endtask

  task automatic check_hs(input int idx, input int exp_c, input logic [8:0] exp_w);
    check($sformatf("hs%0d_cycle", idx), (hs_cyc.size() > idx) ? hs_cyc[idx] : -1, exp_c);
    check($sformatf("hs%0d_fields", idx),
          (hs_word.size() > idx) ? 32'(hs_word[idx]) : 32'hFFFF_FFFF, 32'(exp_w));
  endtask

  task automatic check_done_at(input string name, input int exp_c);
    check(name, (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_outputs", {busy, done, issue_valid, opcode, reg_address, memory_address}, 0);

    // Program load
    for (int i = 0; i < DEPTH; i++) write_prog(i, 9'($urandom));
    write_prog(0, W_LOAD_1_5);
    write_prog(1, W_ADD_0_0);
    write_prog(2, W_STORE_1_9);

    // Single-pass timing
    ready_mode = 0;
    start_run(3);
    wait_done(100);
    check_hs(0, 2, W_LOAD_1_5);
    check_hs(1, 6, W_ADD_0_0);
    check_hs(2, 12, W_STORE_1_9);
    check_done_at("single_done_cycle", 15);
    check("single_busy_cycles", busy_cnt, 14);

    // Back-pressure on the first issue
    ready_mode = 2;
    start_run(3);
    wait_done(100);
    check_hs(0, 5, W_LOAD_1_5);
    check_done_at("bp_done_cycle", 18);

    // Zero length
    ready_mode = 0;
    start_run(0);
    wait_done(20);
    check_done_at("zero_done_cycle", 1);
    check("zero_valid_cycles", valid_cnt, 0);
    check("zero_busy_cycles", busy_cnt, 0);

    // Start and program write ignored while busy
    start_run(3);
    while ((cyc - t0) < 4) step();
    start     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = AW'(1);
    prog_data = W_MUL_2_7;
    step();
    start   = 1'b0;
    prog_we = 1'b0;
    wait_done(100);
    check_hs(1, 6, W_ADD_0_0);
    check_done_at("ignored_done_cycle", 15);
    start_run(3);
    wait_done(100);
    check_hs(1, 6, W_ADD_0_0);

    // Reset during the WAIT of instruction 2
    start_run(3);
    while ((cyc - t0) < 8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_reset_outputs", {busy, done, issue_valid, opcode, reg_address, memory_address}, 0);
    step();
    step();
    check("midrun_no_done", done_cyc.size(), 0);
    start_run(3);
    wait_done(100);
    check_hs(0, 2, W_LOAD_1_5);
    check_hs(2, 12, W_STORE_1_9);

    // Length clamping and full-depth program: sixteen ADDs, 6 cycles each
    for (int i = 0; i < DEPTH; i++) write_prog(i, {2'd0, 2'(i), 5'(i)});
    start_run(20);
    wait_done(300);
    check("clamp_issue_count", hs_cyc.size(), 16);
    check_hs(15, 92, {2'd0, 2'd3, 5'd15});
    check_done_at("clamp_done_cycle", 97);
    start_run(16);
    wait_done(300);
    check_done_at("full_depth_done_cycle", 97);

`ifdef SEQ_LOOP_EN
    write_prog(0, W_MUL_2_3);
    write_prog(1, W_STORE_2_4);
    loop_count = 8'd1;
    start_run(2);
    wait_done(200);
    check_hs(0, 2, W_MUL_2_3);
    check_hs(1, 8, W_STORE_2_4);
    check_hs(2, 12, W_MUL_2_3);
    check_hs(3, 18, W_STORE_2_4);
    check_done_at("loop_done_cycle", 21);
    loop_count = 8'd0;
`endif

    // Randomized programs, lengths and back-pressure against the model
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 4; k++) write_prog($urandom_range(0, DEPTH - 1), 9'($urandom));
`ifdef SEQ_LOOP_EN
      loop_count = 8'($urandom_range(0, 2));
`endif
      start_run($urandom_range(0, 31));
      wait_done(5000);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
